// File: rtl/game_seq.sv
// Game-state sequencer: run/jump/duck/over FSM, jump height, freeze, score ticks and speed level.
// Latency: every output is registered and updates one clk after the qualifying tick edge.
// Backpressure: none, paced by tick only. Ducking is compiled in only when GAME_SEQ_DUCK_EN is defined.
module game_seq #(
    parameter int JUMP_MAX     = 48,
    parameter int JUMP_STEP    = 4,
    parameter int HANG_TICKS   = 2,
    parameter int SCORE_DIV    = 4,
    parameter int SPEED_PERIOD = 64,
    parameter int OVER_WAIT    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       hit,
    output logic [2:0] state,
    output logic       freeze,
    output logic [5:0] y,
    output logic       ducking,
    output logic       score_tick,
    output logic       score_clr,
    output logic [2:0] speed
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_RISE = 3'd2,
        S_HANG = 3'd3,
        S_FALL = 3'd4,
        S_OVER = 3'd5
    } state_t;

    localparam logic [6:0] JMAX7      = 7'(JUMP_MAX);
    localparam logic [6:0] JSTEP7     = 7'(JUMP_STEP);
    localparam logic [7:0] HANG_LAST  = 8'(HANG_TICKS - 1);
    localparam logic [7:0] SCORE_LAST = 8'(SCORE_DIV - 1);
    localparam logic [7:0] SPEED_LAST = 8'(SPEED_PERIOD - 1);
    localparam logic [7:0] OVER_DONE  = 8'(OVER_WAIT);

    state_t     state_q;
    logic       up_q;
    logic       hit_l;
    logic [7:0] hang_cnt;
    logic [7:0] score_cnt;
    logic [7:0] run_cnt;
    logic [7:0] wait_cnt;

    logic       duck_req;
    logic       active;
    logic       up_rise;
    logic       go_over;
    logic       start_run;
    logic       bad_state;
    logic [6:0] y_sum;
    logic [5:0] y_up;
    logic [5:0] y_dn;

`ifdef GAME_SEQ_DUCK_EN
    assign duck_req = down_btn;
`else
    assign duck_req = down_btn & 1'b0;
`endif

    assign active    = (state_q == S_RUN) || (state_q == S_RISE) ||
                       (state_q == S_HANG) || (state_q == S_FALL);
    assign up_rise   = up_btn & ~up_q;
    assign go_over   = tick && active && hit_l;
    assign start_run = tick && up_rise &&
                       ((state_q == S_IDLE) || ((state_q == S_OVER) && (wait_cnt >= OVER_DONE)));
    assign bad_state = (3'(state_q) > 3'd5);

    // Height is summed one bit wider and clamped at the peak so it can never wrap.
    assign y_sum = {1'b0, y} + JSTEP7;
    assign y_up  = (y_sum >= JMAX7) ? JMAX7[5:0] : y_sum[5:0];
    assign y_dn  = y - JSTEP7[5:0];

    assign state = 3'(state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            freeze     <= 1'b1;
            y          <= 6'd0;
            ducking    <= 1'b0;
            score_tick <= 1'b0;
            score_clr  <= 1'b0;
            speed      <= 3'd0;
            up_q       <= 1'b0;
            hit_l      <= 1'b0;
            hang_cnt   <= 8'd0;
            score_cnt  <= 8'd0;
            run_cnt    <= 8'd0;
            wait_cnt   <= 8'd0;
        end else begin
            score_tick <= 1'b0;
            score_clr  <= 1'b0;
            if (tick) begin
                up_q <= up_btn;
            end
            // Latch a collision on any cycle so a one-clock hit between ticks survives.
            if (hit && active) begin
                hit_l <= 1'b1;
            end

            if (bad_state) begin
                state_q <= S_IDLE;
                freeze  <= 1'b1;
                ducking <= 1'b0;
            end else if (go_over) begin
                state_q  <= S_OVER;
                hit_l    <= 1'b0;
                freeze   <= 1'b1;
                ducking  <= 1'b0;
                wait_cnt <= 8'd0;
            end else if (start_run) begin
                state_q   <= S_RUN;
                freeze    <= 1'b0;
                y         <= 6'd0;
                ducking   <= 1'b0;
                speed     <= 3'd0;
                score_clr <= 1'b1;
                hang_cnt  <= 8'd0;
                score_cnt <= 8'd0;
                run_cnt   <= 8'd0;
                wait_cnt  <= 8'd0;
                hit_l     <= 1'b0;
            end else if (tick) begin
                if (active) begin
                    if (score_cnt >= SCORE_LAST) begin
                        score_cnt  <= 8'd0;
                        score_tick <= 1'b1;
                    end else begin
                        score_cnt <= score_cnt + 8'd1;
                    end
                    if (run_cnt >= SPEED_LAST) begin
                        run_cnt <= 8'd0;
                        if (speed != 3'd7) begin
                            speed <= speed + 3'd1;
                        end
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                    end
                end

                case (state_q)
                    S_RUN: begin
                        if (up_btn) begin
                            state_q <= S_RISE;
                            ducking <= 1'b0;
                        end else begin
                            ducking <= duck_req;
                        end
                    end
                    S_RISE: begin
                        y <= y_up;
                        if (y_up == JMAX7[5:0]) begin
                            state_q  <= S_HANG;
                            hang_cnt <= 8'd0;
                        end
                    end
                    S_HANG: begin
                        if (hang_cnt >= HANG_LAST) begin
                            state_q  <= S_FALL;
                            hang_cnt <= 8'd0;
                        end else begin
                            hang_cnt <= hang_cnt + 8'd1;
                        end
                    end
                    S_FALL: begin
                        if ({1'b0, y} <= JSTEP7) begin
                            y       <= 6'd0;
                            state_q <= S_RUN;
                        end else begin
                            y <= y_dn;
                        end
                    end
                    S_OVER: begin
                        if (wait_cnt < OVER_DONE) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_seq.sv
// Scoreboard bench for game_seq: the stimulus queues the expected post-tick outputs, a monitor checks them.
module tb_game_seq;

`ifdef GAME_SEQ_DUCK_EN
    localparam int DUCK = 1;
`else
    localparam int DUCK = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       up_btn;
    logic       down_btn;
    logic       hit;
    logic [2:0] state;
    logic       freeze;
    logic [5:0] y;
    logic       ducking;
    logic       score_tick;
    logic       score_clr;
    logic [2:0] speed;

    game_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .up_btn     (up_btn),
        .down_btn   (down_btn),
        .hit        (hit),
        .state      (state),
        .freeze     (freeze),
        .y          (y),
        .ducking    (ducking),
        .score_tick (score_tick),
        .score_clr  (score_clr),
        .speed      (speed)
    );

    typedef struct {
        int st;
        int frz;
        int yv;
        int dk;
        int spd;
        int nsc;
        int nclr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_st = 0;
    int   rt     = 0;
    int   exp_clr = 0;
    int   n_sc   = 0;
    int   n_clr  = 0;
    logic tick_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) tick_seen <= tick;

    task automatic chk(input string nm, input int got, input int want);
        if (want >= 0) begin
            checks++;
            if (got != want) begin
                errors++;
                $display("FAIL %s got %0d expected %0d at %0t", nm, got, want, $time);
            end
        end
    endtask

    // Monitor: counts pulses continuously, pops one expectation per tick.
    initial begin
        logic prev_sc;
        logic prev_clr;
        exp_t e;
        prev_sc  = 1'b0;
        prev_clr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) n_sc = 0;
            if (score_tick) chk("score_tick_width", int'(prev_sc), 0);
            if (score_clr)  chk("score_clr_width", int'(prev_clr), 0);
            if (score_clr) begin
                n_clr++;
                n_sc = 0;
            end
            if (score_tick) n_sc++;
            prev_sc  = score_tick;
            prev_clr = score_clr;
            if (tick_seen) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty_on_tick", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("state",   int'(state),   e.st);
                    chk("freeze",  int'(freeze),  e.frz);
                    chk("y",       int'(y),       e.yv);
                    chk("ducking", int'(ducking), e.dk);
                    chk("speed",   int'(speed),   e.spd);
                    chk("score_cnt", n_sc,        e.nsc);
                    chk("clr_cnt",   n_clr,       e.nclr);
                end
            end
        end
    end

    // Issue one tick and queue the outputs expected right after it.
    task automatic tk(input int st, input int yv, input int dk);
        exp_t e;
        if (cur_st >= 1 && cur_st <= 4 && st != 5) rt++;
        if (st == 1 && (cur_st == 0 || cur_st == 5)) begin
            rt = 0;
            exp_clr++;
        end
        e.st   = st;
        e.frz  = (st == 0 || st == 5) ? 1 : 0;
        e.yv   = yv;
        e.dk   = dk;
        e.nclr = exp_clr;
        if (st == 5) begin
            e.nsc = -1;
            e.spd = -1;
        end else begin
            e.nsc = rt / 4;
            e.spd = (rt / 64 > 7) ? 7 : rt / 64;
        end
        cur_st = st;
        exp_q.push_back(e);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_hit();
        @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_state",  int'(state),      0);
        chk("rst_freeze", int'(freeze),     1);
        chk("rst_y",      int'(y),          0);
        chk("rst_duck",   int'(ducking),    0);
        chk("rst_stick",  int'(score_tick), 0);
        chk("rst_sclr",   int'(score_clr),  0);
        chk("rst_speed",  int'(speed),      0);
    endtask

    initial begin
        rst_n    = 1'b0;
        tick     = 1'b0;
        up_btn   = 1'b0;
        down_btn = 1'b0;
        hit      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Idle, then start on an up edge.
        tk(0, 0, 0);
        up_btn = 1'b1;
        tk(1, 0, 0);
        up_btn = 1'b0;
        for (int i = 0; i < 3; i++) tk(1, 0, 0);

        // Full jump profile: 12 rise, 2 hang, 12 fall.
        up_btn = 1'b1;
        tk(2, 0, 0);
        up_btn = 1'b0;
        for (int i = 1; i <= 12; i++) tk((i == 12) ? 3 : 2, 4 * i, 0);
        tk(3, 48, 0);
        tk(4, 48, 0);
        for (int i = 1; i <= 12; i++) tk((i == 12) ? 1 : 4, 48 - 4 * i, 0);

        // Long run: score every 4 ticks, speed every 64, saturating at 7.
        while (rt < 1000) tk(1, 0, 0);

        // Duck, then jump wins over duck.
        down_btn = 1'b1;
        tk(1, 0, DUCK);
        tk(1, 0, DUCK);
        up_btn = 1'b1;
        tk(2, 0, 0);
        up_btn   = 1'b0;
        down_btn = 1'b0;

        // One-clock hit between ticks mid-rise.
        tk(2, 4, 0);
        tk(2, 8, 0);
        pulse_hit();
        tk(5, 8, 0);

        // Restart lockout: edge at OVER tick 10 ignored, edge at tick 33 accepted.
        for (int k = 1; k <= 33; k++) begin
            up_btn = (k == 10 || k == 33) ? 1'b1 : 1'b0;
            tk((k == 33) ? 1 : 5, (k == 33) ? 0 : 8, 0);
        end
        up_btn = 1'b0;
        tk(1, 0, 0);

        // Asynchronous reset mid-jump.
        up_btn = 1'b1;
        tk(2, 0, 0);
        up_btn = 1'b0;
        tk(2, 4, 0);
        tk(2, 8, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        cur_st = 0;
        rt     = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tk(0, 0, 0);
        up_btn = 1'b1;
        tk(1, 0, 0);
        up_btn = 1'b0;
        tk(1, 0, 0);

        repeat (4) @(negedge clk);
        chk("queue_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
